// File: rtl/dac_interface_if.sv
// Write port and serial DAC pins for dac_interface.
// The master side is the synth core / bench; the slave side is the transmitter.
interface dac_interface_if;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [11:0] wr_data;
   logic        dout;
   logic        cs_n;
   logic        ldac_n;
   logic        busy;
   logic        frame_done;

   modport master (
      output wr_en, wr_addr, wr_data,
      input  dout, cs_n, ldac_n, busy, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      output dout, cs_n, ldac_n, busy, frame_done
   );
endinterface

// File: rtl/dac_interface.sv
// Round-robin parallel-to-serial transmitter for a 4-channel 12-bit serial DAC.
// Optional DAC_INTERFACE_LDAC_EN: frames skip the update bit and ldac_n pulses once all are sent.
module dac_interface #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic           sclk,
   input  logic           rst,
   dac_interface_if.slave bus
);

`ifdef DAC_INTERFACE_LDAC_EN
   localparam logic UpdBit = 1'b0;
`else
   localparam logic UpdBit = 1'b1;
`endif

   typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

   state_e      state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  gap_cnt_q, gap_cnt_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  sel_q, sel_d;
   logic [3:0]  dirty_q, dirty_d;
   logic [11:0] ch_q [4];
   logic [11:0] ch_d [4];
   logic        frame_done_q, frame_done_d;
`ifdef DAC_INTERFACE_LDAC_EN
   logic        ldac_n_q, ldac_n_d;
`endif

   logic       wr_ok;
   logic       pick_found;
   logic [1:0] pick_ch;
   logic [2:0] idx;

   assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < NUM_CH);

   // First dirty channel at or after the pointer, wrapping modulo NUM_CH.
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      idx        = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = {1'b0, ptr_q} + 3'(i);
         if (idx >= 3'(NUM_CH)) idx = idx - 3'(NUM_CH);
         if (!pick_found && dirty_q[idx[1:0]]) begin
            pick_found = 1'b1;
            pick_ch    = idx[1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      ptr_d        = ptr_q;
      sel_d        = sel_q;
      dirty_d      = dirty_q;
      ch_d         = ch_q;
      frame_done_d = 1'b0;
`ifdef DAC_INTERFACE_LDAC_EN
      ldac_n_d     = 1'b1;
`endif
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               shift_d          = {UpdBit, 1'b0, pick_ch, ch_q[pick_ch]};
               dirty_d[pick_ch] = 1'b0;
               sel_d            = pick_ch;
               bit_cnt_d        = 4'd15;
               state_d          = StShift;
            end
         end
         StShift: begin
            shift_d = {shift_q[14:0], 1'b0};
            if (bit_cnt_q == 4'd0) begin
               state_d      = StGap;
               gap_cnt_d    = 3'(GAP_CYCLES - 1);
               ptr_d        = (sel_q == 2'(NUM_CH - 1)) ? 2'd0 : sel_q + 2'd1;
               frame_done_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q - 4'd1;
            end
         end
         StGap: begin
            if (gap_cnt_q == 3'd0) begin
               state_d = StIdle;
`ifdef DAC_INTERFACE_LDAC_EN
               ldac_n_d = (dirty_q != 4'd0);
`endif
            end else begin
               gap_cnt_d = gap_cnt_q - 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Applied after the load-clear so a write on the load edge keeps the channel dirty.
      if (wr_ok) begin
         ch_d[bus.wr_addr]    = bus.wr_data;
         dirty_d[bus.wr_addr] = 1'b1;
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         ptr_q        <= '0;
         sel_q        <= '0;
         dirty_q      <= '0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 4; i++) ch_q[i] <= '0;
`ifdef DAC_INTERFACE_LDAC_EN
         ldac_n_q     <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         ptr_q        <= ptr_d;
         sel_q        <= sel_d;
         dirty_q      <= dirty_d;
         frame_done_q <= frame_done_d;
         for (int i = 0; i < 4; i++) ch_q[i] <= ch_d[i];
`ifdef DAC_INTERFACE_LDAC_EN
         ldac_n_q     <= ldac_n_d;
`endif
      end
   end

   assign bus.dout       = (state_q == StShift) ? shift_q[15] : 1'b0;
   assign bus.cs_n       = (state_q != StShift);
   assign bus.busy       = (state_q != StIdle);
   assign bus.frame_done = frame_done_q;
`ifdef DAC_INTERFACE_LDAC_EN
   assign bus.ldac_n     = ldac_n_q;
`else
   assign bus.ldac_n     = 1'b1;
`endif

endmodule
